decoder38_scan: RTL and testbench

Sequential driver that sits directly upstream of the 3-to-8 decoder. It generates the decoder's 3-bit select code and active-low enable, and steps through a latched slot mask. Each enabled slot is held for a fixed dwell time. A blanking gap precedes every select change so the decoder outputs never glitch. Supports single-pass and continuous scanning, with a start/stop/busy/done handshake toward the controller.

---
 rtl/scan_pkg.sv | 6 +
 rtl/slot_next_find.sv | 29 ++
 rtl/decoder38_scan.sv | 129 ++++++++++++
 tb/tb_decoder38_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and slot geometry for the decoder scan driver.
package scan_pkg;
   localparam int NUM_SLOTS = 8;
   localparam int SEL_W = 3;
   typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DWELL = 2'd2} state_e;
endpackage

// File: rtl/slot_next_find.sv
// slot_next_find: lowest set mask bit strictly above cur, and lowest set bit overall.
module slot_next_find
   import scan_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] mask_i,
   input  logic [SEL_W-1:0]     cur_i,
   output logic [SEL_W-1:0]     next_o,
   output logic                 found_o,
   output logic [SEL_W-1:0]     first_o,
   output logic                 any_o
);
   always_comb begin
      next_o = '0;
      found_o = 1'b0;
      first_o = '0;
      any_o = 1'b0;
      // Walk downward so the lowest matching index is the last one written.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            first_o = i[SEL_W-1:0];
            any_o = 1'b1;
         end
         if (mask_i[i] && i > int'(cur_i)) begin
            next_o = i[SEL_W-1:0];
            found_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/decoder38_scan.sv
// decoder38_scan: steps a 3-to-8 decoder through a latched slot mask with blanking
// before every select change, single-pass or continuous, with start/stop/busy/done.
module decoder38_scan
   import scan_pkg::*;
#(
   parameter int DWELL_CYC = 4,
   parameter int BLANK_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 cont_i,
   input  logic [NUM_SLOTS-1:0] mask_i,
   output logic [SEL_W-1:0]     sel_o,
   output logic                 en_n_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int CW = $clog2((DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC) + 1);
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYC - 1);

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 en_n_q, en_n_d, busy_q, busy_d, done_q, done_d, cont_q, cont_d;
   logic [NUM_SLOTS-1:0] mask_q, mask_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SEL_W-1:0]     nxt, first;
   logic                 found, any;

   // In IDLE the search looks at the live mask (start), otherwise at the latched copy.
   slot_next_find u_find (
      .mask_i  (state_q == IDLE ? mask_i : mask_q),
      .cur_i   (sel_q),
      .next_o  (nxt),
      .found_o (found),
      .first_o (first),
      .any_o   (any)
   );

   always_comb begin
      state_d = state_q;
      sel_d = sel_q;
      en_n_d = 1'b1;
      done_d = 1'b0;
      mask_d = mask_q;
      cont_d = cont_q;
      cnt_d = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start_i && !stop_i) begin
               if (any) begin
                  mask_d = mask_i;
                  cont_d = cont_i;
                  sel_d = first;
                  state_d = BLANK;
                  cnt_d = BLANK_LD;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         BLANK: begin
            if (stop_i) begin
               state_d = IDLE;
               done_d = 1'b1;
               cnt_d = '0;
            end else if (cnt_q == '0) begin
               state_d = DWELL;
               en_n_d = 1'b0;
               cnt_d = DWELL_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DWELL: begin
            if (stop_i) begin
               state_d = IDLE;
               done_d = 1'b1;
               cnt_d = '0;
            end else if (cnt_q != '0) begin
               en_n_d = 1'b0;
               cnt_d = cnt_q - 1'b1;
            end else if (found || cont_q) begin
               sel_d = found ? nxt : first;
               state_d = BLANK;
               cnt_d = BLANK_LD;
            end else begin
               state_d = IDLE;
               done_d = 1'b1;
               cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d = '0;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q <= '0;
         en_n_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         mask_q <= '0;
         cont_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q <= sel_d;
         en_n_q <= en_n_d;
         busy_q <= busy_d;
         done_q <= done_d;
         mask_q <= mask_d;
         cont_q <= cont_d;
         cnt_q <= cnt_d;
      end
   end

   assign sel_o = sel_q;
   assign en_n_o = en_n_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
endmodule

// File: tb/tb_decoder38_scan.sv
// tb_decoder38_scan: directed scenarios; expected per-cycle {sel,en_n,busy,done} traces are queued then checked.
module tb_decoder38_scan;
   localparam int D = 4;
   localparam int B = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, stop = 1'b0, cont = 1'b0;
   logic [7:0] mask = 8'h00;
   logic [2:0] sel;
   logic       en_n, busy, done;
   logic [5:0] q[$];
   int         vectors = 0, errs = 0;

   decoder38_scan #(.DWELL_CYC(D), .BLANK_CYC(B)) dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .cont_i(cont), .mask_i(mask),
      .sel_o(sel), .en_n_o(en_n), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] v(input int s, input logic e, input logic b, input logic d);
      return {s[2:0], e, b, d};
   endfunction

   task automatic slot(input int s);
      for (int i = 0; i < B; i++) q.push_back(v(s, 1, 1, 0));
      for (int i = 0; i < D; i++) q.push_back(v(s, 0, 1, 0));
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {sel, en_n, busy, done};
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got sel/en_n/busy/done=%b exp %b", tag, obs, exp);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         errs++;
         $display("FAIL %s: scoreboard empty, got %b exp <none>", tag, {sel, en_n, busy, done});
      end else chk(tag, q.pop_front());
   endtask

   task automatic drain(input string tag);
      while (q.size() != 0) cyc(tag);
   endtask

   initial begin
      // 1: reset, then reset mid-scan during sel=3 dwell
      #2 rst = 1'b1;
      #1 chk("reset", v(0, 1, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;
      mask = 8'hFF; cont = 1'b1; start = 1'b1;
      for (int s = 0; s < 3; s++) slot(s);
      q.push_back(v(3, 1, 1, 0));
      q.push_back(v(3, 0, 1, 0));
      cyc("rst_scan");
      start = 1'b0;
      drain("rst_scan");
      rst = 1'b1;
      #1 chk("rst_async", v(0, 1, 0, 0));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) q.push_back(v(0, 1, 0, 0));
      drain("rst_idle");
      // 2: full single pass
      mask = 8'hFF; cont = 1'b0; start = 1'b1;
      for (int s = 0; s < 8; s++) slot(s);
      q.push_back(v(7, 1, 0, 1));
      q.push_back(v(7, 1, 0, 0));
      cyc("full");
      start = 1'b0;
      drain("full");
      // 3: sparse continuous scan, stop in 2nd dwell cycle of second sel=5 visit
      mask = 8'b1010_0100; cont = 1'b1; start = 1'b1;
      slot(2); slot(5); slot(7); slot(2);
      q.push_back(v(5, 1, 1, 0));
      q.push_back(v(5, 0, 1, 0));
      q.push_back(v(5, 0, 1, 0));
      cyc("sparse");
      start = 1'b0;
      drain("sparse");
      stop = 1'b1;
      q.push_back(v(5, 1, 0, 1));
      cyc("stop");
      stop = 1'b0;
      q.push_back(v(5, 1, 0, 0));
      drain("stop");
      // 4: empty mask
      mask = 8'h00; cont = 1'b0; start = 1'b1;
      q.push_back(v(5, 1, 0, 1));
      cyc("empty");
      start = 1'b0;
      repeat (2) q.push_back(v(5, 1, 0, 0));
      drain("empty");
      // 5: start/mask/cont changes while busy are ignored
      mask = 8'h81; cont = 1'b0; start = 1'b1;
      slot(0); slot(7);
      q.push_back(v(7, 1, 0, 1));
      q.push_back(v(7, 1, 0, 0));
      cyc("ignore");
      start = 1'b0;
      cyc("ignore");
      start = 1'b1; mask = 8'hFF; cont = 1'b1;
      cyc("ignore");
      start = 1'b0;
      drain("ignore");
      // 6: start+stop together in IDLE, then single-bit continuous
      mask = 8'h10; cont = 1'b1; start = 1'b1; stop = 1'b1;
      q.push_back(v(7, 1, 0, 0));
      cyc("start_stop");
      start = 1'b0; stop = 1'b0;
      q.push_back(v(7, 1, 0, 0));
      cyc("start_stop");
      start = 1'b1;
      repeat (3) slot(4);
      cyc("single");
      start = 1'b0;
      drain("single");
      stop = 1'b1;
      q.push_back(v(4, 1, 0, 1));
      cyc("single_stop");
      stop = 1'b0;
      q.push_back(v(4, 1, 0, 0));
      drain("single_stop");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
